// File: rtl/mvu_pkg.sv
// Shared types for the MVU bit-serial datapath:
// sequencer state, default sizes and the strobe bundle.
package mvu_pkg;

  localparam int PW_D  = 5;
  localparam int LW_D  = 16;
  localparam int LAT_D = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } shacc_seq_state_t;

  typedef struct packed {
    logic load;
    logic acc;
    logic sh;
  } sa_t;

endpackage

// File: rtl/shacc_dly.sv
// LAT-deep register pipe that aligns the accumulator
// strobes with product arrival; a plain wire when LAT is 0.
module shacc_dly
  import mvu_pkg::*;
#(
  parameter int LAT = LAT_D
) (
  input  logic clk,
  input  logic rst,
  input  sa_t  strb,
  output sa_t  dly
);

  generate
    if (LAT == 0) begin : g_wire
      assign dly = strb;
    end else begin : g_pipe
      sa_t pipe [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= strb;
          for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly = pipe[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/shacc_seq.sv
// Shifter-accumulator lane sequencer: walks every
// (significance, input bit, word) step and drives strobes.
module shacc_seq
  import mvu_pkg::*;
#(
  parameter int PW  = PW_D,
  parameter int LW  = LW_D,
  parameter int LAT = LAT_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] iprec,
  input  logic [PW-1:0] wprec,
  input  logic [LW-1:0] veclen,
  input  logic          isign,
  input  logic          wsign,
  output logic          busy,
  output logic          start_err,
  output logic          issue_valid,
  output logic [PW-1:0] ibit,
  output logic [PW-1:0] wbit,
  output logic [LW-1:0] vidx,
  output logic          neg,
  output logic          sa_load,
  output logic          sa_acc,
  output logic          sa_sh,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int SW = PW + 1;

  shacc_seq_state_t state_q, state_d;

  logic [PW-1:0] ip_q, wp_q;
  logic [LW-1:0] vl_q;
  logic          is_q, ws_q;
  logic [SW-1:0] s_q;
  logic [PW-1:0] ib_q;
  logic [LW-1:0] vi_q;
  logic          first_q, lvl_q;
  logic [7:0]    dcnt_q;
  logic          err_q;

  logic          bad, accept, run;
  logic          vlast, ilast, slast, last;
  logic [SW-1:0] lo, s_nx, s0;
  logic [PW-1:0] ib_rl, wb;
  sa_t           iss, sa;

  assign bad    = (iprec == '0) || (wprec == '0)
               || (veclen == '0);
  assign accept = (state_q == IDLE) && start && !bad;
  assign run    = (state_q == RUN);

  // Lowest ibit on this level keeps wbit inside wprec.
  assign lo    = (s_q >= SW'(wp_q) - SW'(1))
               ? s_q - SW'(wp_q) + SW'(1) : '0;
  assign vlast = (vi_q == vl_q - 1'b1);
  assign ilast = ({1'b0, ib_q} == lo);
  assign slast = (s_q == '0);
  assign last  = vlast && ilast && slast;
  assign s_nx  = s_q - SW'(1);
  assign ib_rl = (s_nx < SW'(ip_q) - SW'(1))
               ? PW'(s_nx) : ip_q - 1'b1;
  assign s0    = SW'(iprec) + SW'(wprec) - SW'(2);
  assign wb    = PW'(s_q - {1'b0, ib_q});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = RUN;
      RUN:   if (last) state_d = (LAT == 0) ? DONE : DRAIN;
      DRAIN: if (dcnt_q == 8'(LAT - 1)) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ip_q    <= '0;
      wp_q    <= '0;
      vl_q    <= '0;
      is_q    <= 1'b0;
      ws_q    <= 1'b0;
      s_q     <= '0;
      ib_q    <= '0;
      vi_q    <= '0;
      first_q <= 1'b0;
      lvl_q   <= 1'b0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && start && bad;
      if (accept) begin
        ip_q    <= iprec;
        wp_q    <= wprec;
        vl_q    <= veclen;
        is_q    <= isign;
        ws_q    <= wsign;
        s_q     <= s0;
        ib_q    <= iprec - 1'b1;
        vi_q    <= '0;
        first_q <= 1'b1;
        lvl_q   <= 1'b1;
        dcnt_q  <= '0;
      end else if (run) begin
        first_q <= 1'b0;
        if (!vlast) begin
          vi_q  <= vi_q + 1'b1;
          lvl_q <= 1'b0;
        end else begin
          vi_q <= '0;
          if (!ilast) begin
            ib_q  <= ib_q - 1'b1;
            lvl_q <= 1'b0;
          end else if (!slast) begin
            s_q   <= s_nx;
            ib_q  <= ib_rl;
            lvl_q <= 1'b1;
          end
        end
      end else if (state_q == DRAIN) begin
        dcnt_q <= dcnt_q + 8'd1;
      end
    end
  end

  assign iss.load = run && first_q;
  assign iss.acc  = run && !first_q;
  assign iss.sh   = run && !first_q && lvl_q;

  shacc_dly #(.LAT(LAT)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .strb (iss),
    .dly  (sa)
  );

  assign busy        = (state_q != IDLE);
  assign start_err   = err_q;
  assign issue_valid = run;
  assign ibit        = run ? ib_q : '0;
  assign wbit        = run ? wb : '0;
  assign vidx        = run ? vi_q : '0;
  assign neg         = run
    && ((is_q && (ib_q == ip_q - 1'b1))
      ^ (ws_q && (wb == wp_q - 1'b1)));
  assign sa_load     = sa.load;
  assign sa_acc      = sa.acc;
  assign sa_sh       = sa.sh;
  assign out_valid   = (state_q == DONE);

endmodule
